// File: rtl/i2s_adc_if.sv
// Bus between the I2S ADC receiver and its environment: codec serial inputs,
// the record-mode enable, and the parallel sample handed to the SRAM writer.
interface i2s_adc_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  enable;
  logic                  adc_lrck;
  logic                  adc_dat;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;
  logic                  frame_err;
  logic                  busy;

  modport master (
    input  enable, adc_lrck, adc_dat,
    output data, ready, frame_err, busy
  );

  modport slave (
    output enable, adc_lrck, adc_dat,
    input  data, ready, frame_err, busy
  );
endinterface

// File: rtl/i2s_adc_receiver.sv
// Deserialises one channel of the WM8731 ADC stream (I2S or left-justified)
// into parallel samples, in the bit-clock domain, with a one-cycle ready strobe.
module i2s_adc_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNEL    = 0,
  parameter int DELAY      = 1
) (
  input  logic clk,
  input  logic rst,
  i2s_adc_if.master bus
);
  localparam int   CW     = $clog2(DATA_WIDTH + 1);
  localparam logic CH_LVL = 1'(CHANNEL != 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SKIP, S_SHIFT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic                  lrck_prev;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic                  ready_q, ready_nxt;
  logic                  err_q, err_nxt;
  logic                  in_ch, ce;

  assign in_ch = (bus.adc_lrck == CH_LVL);
  assign ce    = in_ch && (lrck_prev != CH_LVL);

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (!bus.enable) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: state_nxt = S_WAIT;
        S_WAIT: begin
          if (ce) begin
            if (DELAY != 0) begin
              // The bit on the wire now is the other channel's LSB.
              state_nxt = S_SKIP;
            end else begin
              shreg_nxt = {shreg[DATA_WIDTH-2:0], bus.adc_dat};
              cnt_nxt   = CW'(1);
              state_nxt = S_SHIFT;
            end
          end
        end
        S_SKIP: begin
          shreg_nxt = {shreg[DATA_WIDTH-2:0], bus.adc_dat};
          cnt_nxt   = CW'(1);
          state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          if (!in_ch) begin
            err_nxt   = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            shreg_nxt = {shreg[DATA_WIDTH-2:0], bus.adc_dat};
            cnt_nxt   = cnt + CW'(1);
            if (cnt == CW'(DATA_WIDTH - 1)) state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          data_nxt  = shreg;
          ready_nxt = 1'b1;
          state_nxt = S_WAIT;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: registers update with non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lrck_prev <= 1'b0;
      cnt       <= '0;
      shreg     <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      lrck_prev <= bus.adc_lrck;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      data_q    <= data_nxt;
      ready_q   <= ready_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.data      = data_q;
  assign bus.ready     = ready_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state == S_SKIP) || (state == S_SHIFT);
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench: an I2S left-channel receiver and a left-justified
// right-channel receiver driven from one 32-bit-slot codec stream.
module tb_i2s_adc_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lrck = 1'b1, dat = 1'b0, en0 = 1'b0, en1 = 1'b0;
  int   cyc = 0;
  int   errors = 0, checks = 0;

  typedef struct {int c; logic [15:0] d;} ev_t;
  ev_t rdy0[$], rdy1[$];
  int  err0[$], err1[$];
  int  both_cnt = 0;
  bit  saw_ffff = 1'b0;

  i2s_adc_if #(.DATA_WIDTH(16)) bus0 ();
  i2s_adc_if #(.DATA_WIDTH(16)) bus1 ();

  assign bus0.enable = en0;
  assign bus0.adc_lrck = lrck;
  assign bus0.adc_dat = dat;
  assign bus1.enable = en1;
  assign bus1.adc_lrck = lrck;
  assign bus1.adc_dat = dat;

  i2s_adc_receiver #(.DATA_WIDTH(16), .CHANNEL(0), .DELAY(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  i2s_adc_receiver #(.DATA_WIDTH(16), .CHANNEL(1), .DELAY(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus0.ready) rdy0.push_back('{c: cyc, d: bus0.data});
    if (bus1.ready) rdy1.push_back('{c: cyc, d: bus1.data});
    if (bus0.frame_err) err0.push_back(cyc);
    if (bus1.frame_err) err1.push_back(cyc);
    if ((bus0.ready && bus0.frame_err) || (bus1.ready && bus1.frame_err)) both_cnt++;
    if (bus0.data == 16'hFFFF) saw_ffff = 1'b1;
  end

  task automatic clear_q();
    rdy0.delete(); rdy1.delete(); err0.delete(); err1.delete();
  endtask

  task automatic idle(input int n, input logic l);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lrck = l;
      dat = 1'b0;
    end
  endtask

  // One I2S frame of 64 bit clocks (32-bit slots, 16 data bits one clock after LRCK edge).
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int en_on,
                            input int en_off, input int rise, output int k);
    int pos;
    logic [15:0] w;
    k = 0;
    for (int p = 0; p < 64; p++) begin
      pos = p % 32;
      w = (p < 32) ? l : r;
      @(negedge clk);
      if (p == en_on) en0 = 1'b1;
      if (p == en_off) en0 = 1'b0;
      lrck = (p >= rise);
      dat = (pos >= 1 && pos <= 16) ? w[16-pos] : 1'b0;
      if (p == 0) k = cyc + 1;
    end
  endtask

  // Left-justified frame; k is the edge where LRCK rises (right-channel start).
  task automatic send_lj(input logic [15:0] l, input logic [15:0] r, output int k);
    int pos;
    logic [15:0] w;
    k = 0;
    for (int p = 0; p < 64; p++) begin
      pos = p % 32;
      w = (p < 32) ? l : r;
      @(negedge clk);
      if (p == 0) en1 = 1'b1;
      lrck = (p >= 32);
      dat = (pos <= 15) ? w[15-pos] : 1'b0;
      if (p == 32) k = cyc + 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus0.data !== 16'h0) begin errors++; $display("FAIL reset_data0: got %h want 0000", bus0.data); end
    checks++; if (bus0.ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", bus0.ready); end
    checks++; if (bus0.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err0: got %b want 0", bus0.frame_err); end
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", bus0.busy); end
    checks++; if (bus1.data !== 16'h0) begin errors++; $display("FAIL reset_data1: got %h want 0000", bus1.data); end
    checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", bus1.busy); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int k;
    en0 = 1'b1;
    idle(3, 1'b1);
    clear_q();
    saw_ffff = 1'b0;
    send_frame(16'hA5C3, 16'hFFFF, -1, -1, 32, k);
    idle(3, 1'b1);
    checks++; if (rdy0.size() != 1) begin errors++; $display("FAIL basic_count: got %0d want 1", rdy0.size()); end
    if (rdy0.size() >= 1) begin
      checks++; if (rdy0[0].c != k + 17) begin errors++; $display("FAIL basic_latency: got cycle %0d want %0d", rdy0[0].c, k + 17); end
      checks++; if (rdy0[0].d !== 16'hA5C3) begin errors++; $display("FAIL basic_data: got %h want a5c3", rdy0[0].d); end
    end
    checks++; if (saw_ffff) begin errors++; $display("FAIL basic_right_leak: got ffff on data want never"); end
    checks++; if (err0.size() != 0) begin errors++; $display("FAIL basic_err: got %0d want 0", err0.size()); end
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", bus0.busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    int ks [4];
    vals = '{16'h0001, 16'h8000, 16'h7FFF, 16'h1234};
    clear_q();
    for (int i = 0; i < 4; i++) send_frame(vals[i], ~vals[i], -1, -1, 32, ks[i]);
    idle(3, 1'b1);
    checks++; if (rdy0.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", rdy0.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < rdy0.size()) begin
        checks++; if (rdy0[i].d !== vals[i]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, rdy0[i].d, vals[i]); end
        checks++; if (rdy0[i].c != ks[i] + 17) begin errors++; $display("FAIL b2b_time%0d: got %0d want %0d", i, rdy0[i].c, ks[i] + 17); end
      end
    end
  endtask

  task automatic test_enable_mid();
    int k1, k2;
    en0 = 1'b0;
    idle(2, 1'b1);
    clear_q();
    send_frame(16'hDEAD, 16'h0000, 8, -1, 32, k1);
    send_frame(16'h0F0F, 16'h0000, -1, -1, 32, k2);
    idle(2, 1'b1);
    checks++; if (rdy0.size() != 1) begin errors++; $display("FAIL enmid_count: got %0d want 1", rdy0.size()); end
    if (rdy0.size() >= 1) begin
      checks++; if (rdy0[0].c != k2 + 17) begin errors++; $display("FAIL enmid_time: got %0d want %0d", rdy0[0].c, k2 + 17); end
      checks++; if (rdy0[0].d !== 16'h0F0F) begin errors++; $display("FAIL enmid_data: got %h want 0f0f", rdy0[0].d); end
    end
  endtask

  task automatic test_frame_err();
    int k1, k2;
    clear_q();
    send_frame(16'h3C3C, 16'h0000, -1, -1, 11, k1);
    checks++; if (err0.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", err0.size()); end
    if (err0.size() >= 1) begin
      checks++; if (err0[0] != k1 + 11) begin errors++; $display("FAIL ferr_time: got %0d want %0d", err0[0], k1 + 11); end
    end
    checks++; if (rdy0.size() != 0) begin errors++; $display("FAIL ferr_ready: got %0d want 0", rdy0.size()); end
    checks++; if (bus0.data !== 16'h0F0F) begin errors++; $display("FAIL ferr_hold: got %h want 0f0f", bus0.data); end
    send_frame(16'h2468, 16'h0000, -1, -1, 32, k2);
    idle(2, 1'b1);
    checks++; if (rdy0.size() != 1) begin errors++; $display("FAIL ferr_next_count: got %0d want 1", rdy0.size()); end
    if (rdy0.size() >= 1) begin
      checks++; if (rdy0[0].d !== 16'h2468) begin errors++; $display("FAIL ferr_next_data: got %h want 2468", rdy0[0].d); end
      checks++; if (rdy0[0].c != k2 + 17) begin errors++; $display("FAIL ferr_next_time: got %0d want %0d", rdy0[0].c, k2 + 17); end
    end
  endtask

  task automatic test_enable_drop();
    int k1, k2;
    clear_q();
    send_frame(16'h1111, 16'h0000, 40, 9, 32, k1);
    checks++; if (rdy0.size() != 0 || err0.size() != 0) begin errors++; $display("FAIL drop_strobe: got ready=%0d err=%0d want 0/0", rdy0.size(), err0.size()); end
    checks++; if (bus0.data !== 16'h2468) begin errors++; $display("FAIL drop_hold: got %h want 2468", bus0.data); end
    send_frame(16'h5A5A, 16'h0000, -1, -1, 32, k2);
    idle(2, 1'b1);
    checks++; if (rdy0.size() != 1) begin errors++; $display("FAIL drop_next_count: got %0d want 1", rdy0.size()); end
    if (rdy0.size() >= 1) begin
      checks++; if (rdy0[0].d !== 16'h5A5A) begin errors++; $display("FAIL drop_next_data: got %h want 5a5a", rdy0[0].d); end
      checks++; if (rdy0[0].c != k2 + 17) begin errors++; $display("FAIL drop_next_time: got %0d want %0d", rdy0[0].c, k2 + 17); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      lrck = 1'b0;
      dat = (p >= 1);
    end
    @(posedge clk);
    #2;
    checks++; if (bus0.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", bus0.busy); end
    rst = 1'b1;
    #1;
    checks++; if (bus0.data !== 16'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0000", bus0.data); end
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus0.busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20, 1'b0);
    checks++; if (rdy0.size() != 0 || err0.size() != 0) begin errors++; $display("FAIL rstmid_strobe: got ready=%0d err=%0d want 0/0", rdy0.size(), err0.size()); end
  endtask

  task automatic test_left_justified();
    int k;
    en0 = 1'b0;
    clear_q();
    send_lj(16'hBEEF, 16'hC001, k);
    idle(3, 1'b0);
    checks++; if (rdy1.size() != 1) begin errors++; $display("FAIL lj_count: got %0d want 1", rdy1.size()); end
    if (rdy1.size() >= 1) begin
      checks++; if (rdy1[0].d !== 16'hC001) begin errors++; $display("FAIL lj_data: got %h want c001", rdy1[0].d); end
      checks++; if (rdy1[0].c != k + 16) begin errors++; $display("FAIL lj_time: got %0d want %0d", rdy1[0].c, k + 16); end
    end
    checks++; if (err1.size() != 0) begin errors++; $display("FAIL lj_err: got %0d want 0", err1.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_enable_mid();
    test_frame_err();
    test_enable_drop();
    test_reset_mid();
    test_left_justified();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
